// File: rtl/rns_reconstruct.sv
// rtl/rns_reconstruct.sv - sequential two-domain RNS-to-binary converter (mixed-radix).
// Optional RNS_RECON_SIGNED_EN maps the result to a symmetric signed range.
module rns_reconstruct #(
  parameter logic [17:0] MODULI  = {9'd129, 9'd256},
  parameter logic [8:0]  M0_INV  = 9'd64,
  parameter int          OUT_WID = 16,
  parameter int          TAG_WID = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0]        residues,
  input  logic [TAG_WID-1:0] tag_in,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_WID-1:0] result,
  output logic [TAG_WID-1:0] tag_out,
  output logic               err
);

  localparam logic [8:0]  M0   = MODULI[8:0];
  localparam logic [8:0]  M1   = MODULI[17:9];
  localparam logic [31:0] PROD = 32'(M0) * 32'(M1);
  localparam logic [31:0] HALF = PROD >> 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DIFF = 3'd1;
  localparam logic [2:0] S_MUL  = 3'd2;
  localparam logic [2:0] S_COMB = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [7:0]         r0_q, r0_d;
  logic [7:0]         r1_q, r1_d;
  logic [TAG_WID-1:0] tag_q, tag_d;
  logic               err_q, err_d;
  logic [8:0]         d_q, d_d;
  logic [8:0]         acc_q, acc_d;
  logic [3:0]         k_q, k_d;
  logic [OUT_WID-1:0] result_q, result_d;
  logic [TAG_WID-1:0] tag_out_q, tag_out_d;
  logic               err_out_q, err_out_d;
  logic               out_valid_q, out_valid_d;

  logic [8:0]  t_w;
  logic [9:0]  diff_w;
  logic [8:0]  d_w;
  logic [9:0]  dbl_w, dbl_r_w, sum_w, sum_r_w;
  logic [31:0] x_w;
  logic [OUT_WID-1:0] comb_w;

  // d = (r1 - r0) mod M1, with r0 first folded once into [0, M1)
  always_comb begin
    t_w    = ({1'b0, r0_q} >= M1) ? ({1'b0, r0_q} - M1) : {1'b0, r0_q};
    diff_w = {2'b00, r1_q} - {1'b0, t_w};
    if (diff_w[9]) begin
      diff_w = diff_w + {1'b0, M1};
    end
    d_w = diff_w[8:0];
  end

  // One MSB-first step of acc = d * M0_INV mod M1
  always_comb begin
    dbl_w   = {acc_q, 1'b0};
    dbl_r_w = (dbl_w >= {1'b0, M1}) ? (dbl_w - {1'b0, M1}) : dbl_w;
    sum_w   = dbl_r_w + (M0_INV[k_q] ? {1'b0, d_q} : 10'd0);
    sum_r_w = (sum_w >= {1'b0, M1}) ? (sum_w - {1'b0, M1}) : sum_w;
  end

  always_comb begin
    x_w = 32'(r0_q) + 32'(M0) * 32'(acc_q);
`ifdef RNS_RECON_SIGNED_EN
    if (x_w >= HALF) begin
      x_w = x_w - PROD;
    end
`endif
    comb_w = err_q ? '0 : x_w[OUT_WID-1:0];
  end

  always_comb begin
    state_d     = state_q;
    r0_d        = r0_q;
    r1_d        = r1_q;
    tag_d       = tag_q;
    err_d       = err_q;
    d_d         = d_q;
    acc_d       = acc_q;
    k_d         = k_q;
    result_d    = result_q;
    tag_out_d   = tag_out_q;
    err_out_d   = err_out_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          r0_d    = residues[7:0];
          r1_d    = residues[15:8];
          tag_d   = tag_in;
          err_d   = ({1'b0, residues[7:0]} >= M0) || ({1'b0, residues[15:8]} >= M1);
          state_d = S_DIFF;
        end
      end
      S_DIFF: begin
        d_d     = d_w;
        acc_d   = '0;
        k_d     = 4'd8;
        state_d = S_MUL;
      end
      S_MUL: begin
        acc_d = sum_r_w[8:0];
        if (k_q == 4'd0) begin
          state_d = S_COMB;
        end else begin
          k_d = k_q - 4'd1;
        end
      end
      S_COMB: begin
        result_d    = comb_w;
        tag_out_d   = tag_q;
        err_out_d   = err_q;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Flush abandons the op but leaves the last delivered outputs untouched
    if (flush && state_q != S_IDLE) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      result_d    = result_q;
      tag_out_d   = tag_out_q;
      err_out_d   = err_out_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      r0_q        <= '0;
      r1_q        <= '0;
      tag_q       <= '0;
      err_q       <= 1'b0;
      d_q         <= '0;
      acc_q       <= '0;
      k_q         <= '0;
      result_q    <= '0;
      tag_out_q   <= '0;
      err_out_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      r0_q        <= r0_d;
      r1_q        <= r1_d;
      tag_q       <= tag_d;
      err_q       <= err_d;
      d_q         <= d_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      result_q    <= result_d;
      tag_out_q   <= tag_out_d;
      err_out_q   <= err_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign tag_out   = tag_out_q;
  assign err       = err_out_q;

endmodule

// File: tb/tb_rns_reconstruct.sv
// tb/tb_rns_reconstruct.sv - randomized self-checking bench for rns_reconstruct against a CRT search model.
module tb_rns_reconstruct;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] residues;
  logic [2:0]  tag_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [2:0]  tag_out;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  rns_reconstruct dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .residues(residues), .tag_in(tag_in), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .tag_out(tag_out), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: brute-force CRT search, then optional signed mapping
  function automatic logic [15:0] ref_x(input int r1, input int r0);
    int x = 0;
    if (r1 >= 129 || r0 >= 256) return 16'd0;
    for (int i = 0; i < 256 * 129; i++) begin
      if (i % 256 == r0 && i % 129 == r1) x = i;
    end
`ifdef RNS_RECON_SIGNED_EN
    if (x >= (256 * 129) / 2) x = x - 256 * 129;
`endif
    return 16'(x);
  endfunction

  task automatic send(input logic [7:0] r1, input logic [7:0] r0, input logic [2:0] tg);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(n < 50), 32'd1);
    residues = {r1, r0};
    tag_in   = tg;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name, input logic [15:0] exp_res, input logic [2:0] exp_tag,
                          input logic exp_err);
    int lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_lat"}, 32'(lat), 32'd11);
    chk({name, "_res"}, 32'(result), 32'(exp_res));
    chk({name, "_tag"}, 32'(tag_out), 32'(exp_tag));
    chk({name, "_err"}, 32'(err), 32'(exp_err));
  endtask

  task automatic consume(input string name);
    @(negedge clk);
    chk({name, "_ov_clr"}, 32'(out_valid), 32'd0);
    chk({name, "_rdy"}, 32'(in_ready), 32'd1);
  endtask

  task automatic op(input string name, input logic [7:0] r1, input logic [7:0] r0, input logic [2:0] tg,
                    input logic [15:0] exp_res, input logic exp_err);
    send(r1, r0, tg);
    wait_out(name, exp_res, tg, exp_err);
    consume(name);
  endtask

  initial begin
    logic [15:0] held;
    int seen;
    reset = 1'b1; in_valid = 1'b0; residues = '0; tag_in = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_res", 32'(result), 32'd0);
    chk("rst_tag", 32'(tag_out), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    op("x1000", 8'd97, 8'd232, 3'd5, 16'd1000, 1'b0);
`ifdef RNS_RECON_SIGNED_EN
    op("x80ff", 8'd128, 8'd255, 3'd1, 16'hFFFF, 1'b0);
    op("x4080", 8'd0, 8'd128, 3'd2, 16'hBF80, 1'b0);
`else
    op("x80ff", 8'd128, 8'd255, 3'd1, 16'h80FF, 1'b0);
    op("x4080", 8'd0, 8'd128, 3'd2, 16'h4080, 1'b0);
`endif
    op("zero", 8'd0, 8'd0, 3'd3, 16'd0, 1'b0);
    op("errr1", 8'd200, 8'd10, 3'd6, 16'd0, 1'b1);

    // Back-pressure: outputs hold, competing request stays unaccepted until IDLE
    out_ready = 1'b0;
    send(8'd97, 8'd232, 3'd4);
    wait_out("hold", 16'd1000, 3'd4, 1'b0);
    residues = 16'h0000; tag_in = 3'd7; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_ov", 32'(out_valid), 32'd1);
      chk("hold_res", 32'(result), 32'd1000);
      chk("hold_tag", 32'(tag_out), 32'd4);
      chk("hold_rdy", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("rel_rdy", 32'(in_ready), 32'd1);
    chk("rel_ov", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("rel_acc", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    wait_out("relq", 16'd0, 3'd7, 1'b0);
    consume("relq");

    // Flush mid-multiply
    send(8'd5, 8'd77, 3'd2);
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_rdy", 32'(in_ready), 32'd1);
    chk("fl_ov", 32'(out_valid), 32'd0);
    chk("fl_res_kept", 32'(result), 32'd0);
    chk("fl_tag_kept", 32'(tag_out), 32'd7);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("fl_no_out", 32'(seen), 32'd0);
    op("postfl", 8'd97, 8'd232, 3'd5, 16'd1000, 1'b0);

    // Reset mid-multiply
    send(8'd20, 8'd30, 3'd3);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mr_rdy", 32'(in_ready), 32'd1);
    chk("mr_ov", 32'(out_valid), 32'd0);
    chk("mr_res", 32'(result), 32'd0);
    chk("mr_tag", 32'(tag_out), 32'd0);
    chk("mr_err", 32'(err), 32'd0);
    op("postrst", 8'd97, 8'd232, 3'd5, 16'd1000, 1'b0);

    // Randomized residues, some with r1 out of range
    for (int i = 0; i < 24; i++) begin
      logic [7:0] r1, r0;
      logic [2:0] tg;
      int stall;
      r1 = 8'($urandom_range(0, 150));
      r0 = 8'($urandom_range(0, 255));
      tg = 3'($urandom_range(0, 7));
      stall = int'($urandom_range(0, 2));
      out_ready = (stall == 0);
      send(r1, r0, tg);
      wait_out("rnd", ref_x(int'(r1), int'(r0)), tg, r1 >= 8'd129);
      held = result;
      repeat (stall) begin
        @(negedge clk);
        chk("rnd_stable", 32'(result), 32'(held));
      end
      out_ready = 1'b1;
      consume("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
